// File: rtl/debug_cmd_seq_pkg.sv
// Shared debug command definitions.
// Holds the abstract command encodings, field extractors, the executor state
// enum and the decode classes. The field positions match the DM's command
// decoding, so both sides interpret a command word the same way.
package debug_cmd_seq_pkg;

  localparam logic [7:0]  CMD_AAR   = 8'd0;
  localparam logic [7:0]  CMD_AAM   = 8'd2;

  // regno of x0; GPRs occupy GPR_BASE..GPR_BASE+31
  localparam logic [15:0] GPR_BASE  = 16'h1000;
  // regnos below this value address the CSR file directly
  localparam logic [15:0] CSR_LIMIT = 16'h1000;

  localparam logic [1:0]  SIZE_BYTE = 2'd0;
  localparam logic [1:0]  SIZE_HALF = 2'd1;
  localparam logic [1:0]  SIZE_WORD = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DECODE,
    ST_RF_READ,
    ST_MEM_REQ,
    ST_MEM_WAIT,
    ST_FINISH
  } state_e;

  // What a captured command resolves to in the DECODE cycle.
  typedef enum logic [2:0] {
    DEC_NONE,    // done with no access and no flag
    DEC_EXC,     // done with exception
    DEC_BUS,     // done with bus error, nothing issued
    DEC_CSR,     // CSR access this cycle
    DEC_GPR_WR,  // GPR write strobe this cycle
    DEC_GPR_RD,  // GPR read, result next cycle
    DEC_MEM      // memory access
  } dec_e;

  function automatic logic [7:0] cmd_type(input logic [31:0] cmd);
    return cmd[31:24];
  endfunction

  function automatic logic [2:0] cmd_size(input logic [31:0] cmd);
    return cmd[22:20];
  endfunction

  function automatic logic cmd_aampostinc(input logic [31:0] cmd);
    return cmd[19];
  endfunction

  function automatic logic cmd_postexec(input logic [31:0] cmd);
    return cmd[18];
  endfunction

  function automatic logic cmd_transfer(input logic [31:0] cmd);
    return cmd[17];
  endfunction

  function automatic logic cmd_write(input logic [31:0] cmd);
    return cmd[16];
  endfunction

  function automatic logic [15:0] cmd_regno(input logic [31:0] cmd);
    return cmd[15:0];
  endfunction

  // Natural alignment check for a memory access of the given size.
  function automatic logic addr_misaligned(input logic [2:0] size,
                                           input logic [1:0] addr_lo);
    logic mis;
    mis = 1'b0;
    case (size)
      3'd1:    mis = addr_lo[0];
      3'd2:    mis = |addr_lo;
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/debug_cmd_seq_if.sv
// Interfaces of the hart-side debug command executor.
// debug_cmd_seq_if : DM <-> executor command handshake.
//   exec/command/data0_in/data1_in from the DM; data0_out/write/done/
//   exception/bus back to the DM. slave = executor side, master = DM side.
// debug_cmd_seq_mem_if : executor data-memory master port.
//   req/we/addr/size/wdata out, gnt/rvalid/rdata/err back.
//   master = executor side, slave = memory side.
interface debug_cmd_seq_if;
  logic        exec;
  logic [31:0] command;
  logic [31:0] data0_in;
  logic [31:0] data1_in;
  logic [31:0] data0_out;
  logic        write;
  logic        done;
  logic        exception;
  logic        bus;

  modport slave (
    input  exec, command, data0_in, data1_in,
    output data0_out, write, done, exception, bus
  );

  modport master (
    output exec, command, data0_in, data1_in,
    input  data0_out, write, done, exception, bus
  );
endinterface

interface debug_cmd_seq_mem_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [1:0]  mem_size;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        mem_err;

  modport master (
    output mem_req, mem_we, mem_addr, mem_size, mem_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata, mem_err
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_size, mem_wdata,
    output mem_gnt, mem_rvalid, mem_rdata, mem_err
  );
endinterface

// File: rtl/debug_cmd_lane.sv
// Byte/half lane handling for the debug memory path.
// Ports:
//   i_size     access size (0=byte, 1=half, 2=word)
//   i_addr_lo  byte offset within the word
//   i_rdata    raw 32-bit read word from memory
//   i_wdata    write value, right-aligned
//   o_rdata    selected lane, zero-extended
//   o_wdata    write value replicated across all lanes of its size
module debug_cmd_lane
  import debug_cmd_seq_pkg::*;
(
  input  logic [1:0]  i_size,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_rdata,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_rdata,
  output logic [31:0] o_wdata
);

  logic [31:0] w_shifted;

  // Move the addressed lane down to bit 0, then trim by size.
  assign w_shifted = i_rdata >> {i_addr_lo, 3'b000};

  always_comb begin
    o_rdata = i_rdata;
    o_wdata = i_wdata;
    case (i_size)
      SIZE_BYTE: begin
        o_rdata = {24'd0, w_shifted[7:0]};
        o_wdata = {4{i_wdata[7:0]}};
      end
      SIZE_HALF: begin
        o_rdata = {16'd0, w_shifted[15:0]};
        o_wdata = {2{i_wdata[15:0]}};
      end
      default: begin
        o_rdata = i_rdata;
        o_wdata = i_wdata;
      end
    endcase
  end

endmodule

// File: rtl/debug_cmd_seq.sv
// Hart-side abstract command executor.
// Executes Access Register (GPR/CSR) and Access Memory commands handed over
// by the debug module and reports completion with done plus an optional
// exception or bus qualifier. cmderr/busy/postincrement/autoexec stay in DM.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   dm                command handshake with the DM (slave side)
//   mem               data-memory master port
//   o_rf_addr/o_rf_we/o_rf_wdata, i_rf_rdata   GPR file (1-cycle sync read)
//   o_csr_addr/o_csr_re/o_csr_we/o_csr_wdata,
//   i_csr_rdata/i_csr_illegal                  CSR file (combinational)
module debug_cmd_seq
  import debug_cmd_seq_pkg::*;
#(
  parameter int unsigned TimeoutCycles = 64,
  parameter logic [15:0] GprBase       = GPR_BASE
) (
  input  logic                   clk,
  input  logic                   rst_n,
  debug_cmd_seq_if.slave         dm,
  debug_cmd_seq_mem_if.master    mem,
  output logic [4:0]             o_rf_addr,
  output logic                   o_rf_we,
  output logic [31:0]            o_rf_wdata,
  input  logic [31:0]            i_rf_rdata,
  output logic [11:0]            o_csr_addr,
  output logic                   o_csr_re,
  output logic                   o_csr_we,
  output logic [31:0]            o_csr_wdata,
  input  logic [31:0]            i_csr_rdata,
  input  logic                   i_csr_illegal
);

  localparam logic [31:0] WdLimit = TimeoutCycles - 32'd1;

  state_e      r_state, w_state_next;
  logic [31:0] r_cmd;
  logic [31:0] r_data0, w_data0_next;
  logic        r_write, w_write_next;
  logic        r_exc, w_exc_next;
  logic        r_bus, w_bus_next;
  logic [31:0] r_wdog, w_wdog_next;
  logic [31:0] r_mem_addr;
  logic [1:0]  r_mem_size;
  logic        r_mem_we;
  logic [31:0] r_mem_wdata;
  logic        w_mem_load;

  dec_e        w_dec;
  logic [7:0]  w_type;
  logic [2:0]  w_size;
  logic [15:0] w_regno;
  logic [15:0] w_gpr_off;
  logic        w_is_gpr;
  logic        w_is_wr;
  logic        w_wdog_hit;
  logic        w_in_decode;
  logic [31:0] w_lane_rdata;
  logic [31:0] w_lane_wdata;
  logic        w_unused;

  assign w_type    = cmd_type(r_cmd);
  assign w_size    = cmd_size(r_cmd);
  assign w_regno   = cmd_regno(r_cmd);
  assign w_is_wr   = cmd_write(r_cmd);
  assign w_gpr_off = w_regno - GprBase;
  assign w_is_gpr  = (w_regno >= GprBase) && (w_gpr_off < 16'd32);
  assign w_unused  = ^{r_cmd[23], cmd_aampostinc(r_cmd)};

  // Command classification, first matching rule wins.
  always_comb begin
    w_dec = DEC_NONE;
    if (w_type == CMD_AAR) begin
      if (cmd_postexec(r_cmd))       w_dec = DEC_EXC;
      else if (!cmd_transfer(r_cmd)) w_dec = DEC_NONE;
      else if (w_size != 3'd2)       w_dec = DEC_NONE;
      else if (w_regno < CSR_LIMIT)  w_dec = DEC_CSR;
      else if (w_is_gpr)             w_dec = w_is_wr ? DEC_GPR_WR : DEC_GPR_RD;
      else                           w_dec = DEC_EXC;
    end else if (w_type == CMD_AAM) begin
      if (w_size > 3'd2)                                  w_dec = DEC_NONE;
      else if (addr_misaligned(w_size, dm.data1_in[1:0])) w_dec = DEC_BUS;
      else                                                w_dec = DEC_MEM;
    end
  end

  // Strobes fire only while exec is still held, so an aborted command
  // leaves no side effect in the register or CSR file.
  assign w_in_decode = (r_state == ST_DECODE) && dm.exec;

  assign o_csr_re    = w_in_decode && (w_dec == DEC_CSR) && !w_is_wr;
  assign o_csr_we    = w_in_decode && (w_dec == DEC_CSR) && w_is_wr;
  assign o_csr_addr  = (w_in_decode && (w_dec == DEC_CSR)) ? w_regno[11:0] : 12'd0;
  assign o_csr_wdata = o_csr_we ? dm.data0_in : 32'd0;

  assign o_rf_we     = w_in_decode && (w_dec == DEC_GPR_WR);
  assign o_rf_wdata  = o_rf_we ? dm.data0_in : 32'd0;
  // The address must already be valid in DECODE because the read is synchronous.
  assign o_rf_addr   = ((r_state == ST_DECODE &&
                         (w_dec == DEC_GPR_RD || w_dec == DEC_GPR_WR)) ||
                        r_state == ST_RF_READ) ? w_gpr_off[4:0] : 5'd0;

  // >= rather than == so a grant landing on the last allowed cycle still
  // leaves the response phase bounded.
  assign w_wdog_hit = (TimeoutCycles != 0) && (r_wdog >= WdLimit);

  debug_cmd_lane u_lane (
    .i_size    (r_mem_size),
    .i_addr_lo (r_mem_addr[1:0]),
    .i_rdata   (mem.mem_rdata),
    .i_wdata   (r_mem_wdata),
    .o_rdata   (w_lane_rdata),
    .o_wdata   (w_lane_wdata)
  );

  always_comb begin
    w_state_next = r_state;
    w_data0_next = r_data0;
    w_write_next = 1'b0;
    w_exc_next   = r_exc;
    w_bus_next   = r_bus;
    w_wdog_next  = r_wdog;
    w_mem_load   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_exc_next = 1'b0;
        w_bus_next = 1'b0;
        if (dm.exec) w_state_next = ST_DECODE;
      end
      ST_DECODE: begin
        if (!dm.exec) begin
          w_state_next = ST_IDLE;
        end else begin
          w_state_next = ST_FINISH;
          case (w_dec)
            DEC_EXC: w_exc_next = 1'b1;
            DEC_BUS: w_bus_next = 1'b1;
            DEC_CSR: begin
              if (i_csr_illegal) begin
                w_exc_next = 1'b1;
              end else if (!w_is_wr) begin
                w_data0_next = i_csr_rdata;
                w_write_next = 1'b1;
              end
            end
            DEC_GPR_RD: w_state_next = ST_RF_READ;
            DEC_MEM: begin
              w_mem_load   = 1'b1;
              w_wdog_next  = 32'd0;
              w_state_next = ST_MEM_REQ;
            end
            default: ;
          endcase
        end
      end
      ST_RF_READ: begin
        if (!dm.exec) begin
          w_state_next = ST_IDLE;
        end else begin
          w_data0_next = i_rf_rdata;
          w_write_next = 1'b1;
          w_state_next = ST_FINISH;
        end
      end
      ST_MEM_REQ: begin
        if (!dm.exec) begin
          w_state_next = ST_IDLE;
        end else if (mem.mem_gnt) begin
          w_wdog_next  = r_wdog + 32'd1;
          w_state_next = ST_MEM_WAIT;
        end else if (w_wdog_hit) begin
          w_bus_next   = 1'b1;
          w_state_next = ST_FINISH;
        end else begin
          w_wdog_next  = r_wdog + 32'd1;
        end
      end
      ST_MEM_WAIT: begin
        if (!dm.exec) begin
          w_state_next = ST_IDLE;
        end else if (mem.mem_rvalid) begin
          w_state_next = ST_FINISH;
          if (mem.mem_err) begin
            w_bus_next = 1'b1;
          end else if (!r_mem_we) begin
            w_data0_next = w_lane_rdata;
            w_write_next = 1'b1;
          end
        end else if (w_wdog_hit) begin
          w_bus_next   = 1'b1;
          w_state_next = ST_FINISH;
        end else begin
          w_wdog_next  = r_wdog + 32'd1;
        end
      end
      ST_FINISH: w_state_next = ST_IDLE;
      default:   w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_cmd       <= 32'd0;
      r_data0     <= 32'd0;
      r_write     <= 1'b0;
      r_exc       <= 1'b0;
      r_bus       <= 1'b0;
      r_wdog      <= 32'd0;
      r_mem_addr  <= 32'd0;
      r_mem_size  <= 2'd0;
      r_mem_we    <= 1'b0;
      r_mem_wdata <= 32'd0;
    end else begin
      r_state <= w_state_next;
      r_data0 <= w_data0_next;
      r_write <= w_write_next;
      r_exc   <= w_exc_next;
      r_bus   <= w_bus_next;
      r_wdog  <= w_wdog_next;
      if (r_state == ST_IDLE && dm.exec) r_cmd <= dm.command;
      // Request fields are frozen for the whole request phase.
      if (w_mem_load) begin
        r_mem_addr  <= dm.data1_in;
        r_mem_size  <= w_size[1:0];
        r_mem_we    <= w_is_wr;
        r_mem_wdata <= dm.data0_in;
      end
    end
  end

  assign dm.data0_out  = r_data0;
  assign dm.write      = r_write;
  assign dm.done       = (r_state == ST_FINISH);
  assign dm.exception  = dm.done && r_exc;
  assign dm.bus        = dm.done && r_bus && !r_exc;

  assign mem.mem_req   = (r_state == ST_MEM_REQ);
  assign mem.mem_we    = r_mem_we;
  assign mem.mem_addr  = r_mem_addr;
  assign mem.mem_size  = r_mem_size;
  assign mem.mem_wdata = w_lane_wdata;

endmodule

// File: tb/tb_debug_cmd_seq.sv
module tb_debug_cmd_seq;

  typedef struct packed {
    logic        wr;
    logic [31:0] data;
    logic        exc;
    logic        bus;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  debug_cmd_seq_if     dm_if();
  debug_cmd_seq_mem_if mem_if();

  logic [4:0]  rf_addr;
  logic        rf_we;
  logic [31:0] rf_wdata;
  logic [31:0] rf_rdata;
  logic [11:0] csr_addr;
  logic        csr_re;
  logic        csr_we;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;
  logic        csr_illegal;

  debug_cmd_seq #(.TimeoutCycles(64)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .dm            (dm_if),
    .mem           (mem_if),
    .o_rf_addr     (rf_addr),
    .o_rf_we       (rf_we),
    .o_rf_wdata    (rf_wdata),
    .i_rf_rdata    (rf_rdata),
    .o_csr_addr    (csr_addr),
    .o_csr_re      (csr_re),
    .o_csr_we      (csr_we),
    .o_csr_wdata   (csr_wdata),
    .i_csr_rdata   (csr_rdata),
    .i_csr_illegal (csr_illegal)
  );

  // Register file model, 1-cycle synchronous read, preload port for the bench.
  logic [31:0] rf_mem [32];
  logic        pre_we = 1'b0;
  logic [4:0]  pre_addr = 5'd0;
  logic [31:0] pre_data = 32'd0;
  always @(posedge clk) begin
    rf_rdata <= rf_mem[rf_addr];
    if (rf_we)  rf_mem[rf_addr]  <= rf_wdata;
    if (pre_we) rf_mem[pre_addr] <= pre_data;
  end

  // CSR file model.
  logic [31:0] csr_val = 32'd0;
  logic        illegal_en = 1'b0;
  assign csr_rdata   = csr_val;
  assign csr_illegal = illegal_en & (csr_re | csr_we);

  // Memory model: grant in the request cycle, response one cycle later.
  logic        gnt_en = 1'b1;
  logic        resp_en = 1'b1;
  logic [31:0] rdata_val = 32'd0;
  logic        err_val = 1'b0;
  assign mem_if.mem_gnt = mem_if.mem_req & gnt_en;
  always @(posedge clk) begin
    mem_if.mem_rvalid <= mem_if.mem_req & mem_if.mem_gnt & resp_en;
    mem_if.mem_rdata  <= rdata_val;
    mem_if.mem_err    <= err_val;
  end

  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%08h want=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input logic wr, input logic [31:0] d,
                              input logic ex, input logic bs);
    exp_t e;
    e.wr = wr; e.data = d; e.exc = ex; e.bus = bs;
    return e;
  endfunction

  // Scoreboard: popped whenever the DUT signals done.
  exp_t sb_q[$];
  exp_t mon_e;
  always @(negedge clk) begin
    if (rst_n) begin
      if (dm_if.done) begin
        if (sb_q.size() == 0) begin
          chk("sb_empty_at_done", sb_q.size(), 1);
        end else begin
          mon_e = sb_q.pop_front();
          chk("write", dm_if.write, mon_e.wr);
          if (mon_e.wr) chk("data0_out", dm_if.data0_out, mon_e.data);
          chk("exception", dm_if.exception, mon_e.exc);
          chk("bus", dm_if.bus, mon_e.bus);
        end
      end else if (dm_if.write) begin
        chk("write_wo_done", dm_if.done, 1);
      end
    end
  end

  int          obs_lat, obs_mreq, obs_cwe, obs_cre, obs_rfwe;
  logic [4:0]  obs_rfa;
  logic [31:0] obs_cwd, obs_mwd, obs_maddr;
  logic [11:0] obs_caddr;
  logic [1:0]  obs_msz;

  task automatic run_cmd(input string name, input logic [31:0] cmd,
                         input logic [31:0] d0, input logic [31:0] d1, input exp_t e);
    logic got;
    @(negedge clk);
    dm_if.command  = cmd;
    dm_if.data0_in = d0;
    dm_if.data1_in = d1;
    dm_if.exec     = 1'b1;
    sb_q.push_back(e);
    obs_lat = 0; obs_mreq = 0; obs_cwe = 0; obs_cre = 0; obs_rfwe = 0;
    obs_rfa = '0; obs_cwd = '0; obs_mwd = '0; obs_maddr = '0; obs_caddr = '0; obs_msz = '0;
    got = 1'b0;
    for (int c = 1; c <= 200 && !got; c++) begin
      @(negedge clk);
      if (mem_if.mem_req) begin
        obs_mreq++; obs_msz = mem_if.mem_size; obs_mwd = mem_if.mem_wdata; obs_maddr = mem_if.mem_addr;
      end
      if (csr_we) begin obs_cwe++; obs_cwd = csr_wdata; obs_caddr = csr_addr; end
      if (csr_re) obs_cre++;
      if (rf_we)  obs_rfwe++;
      if (c == 1) obs_rfa = rf_addr;
      if (dm_if.done) begin got = 1'b1; obs_lat = c; end
    end
    chk({name, "_done_seen"}, got, 1);
    dm_if.exec = 1'b0;
    $display("txn %s cmd=%08h d0=%08h d1=%08h lat=%0d data0=%08h", name, cmd, d0, d1,
             obs_lat, dm_if.data0_out);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got=running want=finished");
    $fatal(1);
  end

  initial begin
    int seen;
    int n_done;
    dm_if.exec = 1'b0; dm_if.command = '0; dm_if.data0_in = '0; dm_if.data1_in = '0;
    pre_we = 1'b1; pre_addr = 5'd5; pre_data = 32'hDEADBEEF;
    repeat (3) @(negedge clk);
    pre_we = 1'b0;
    chk("rst_done", dm_if.done, 0);
    chk("rst_write", dm_if.write, 0);
    chk("rst_data0", dm_if.data0_out, 0);
    chk("rst_mem_req", mem_if.mem_req, 0);
    chk("rst_rf_we", rf_we, 0);
    chk("rst_csr_we", csr_we, 0);
    rst_n = 1'b1;

    run_cmd("aar_rd_x5", 32'h00221005, 0, 0, mk(1, 32'hDEADBEEF, 0, 0));
    chk("x5_lat", obs_lat, 3);
    chk("x5_rf_addr", obs_rfa, 5);
    chk("x5_csr_strobes", obs_cwe + obs_cre, 0);

    run_cmd("aar_wr_csr", 32'h002307B1, 32'h80000000, 0, mk(0, 0, 0, 0));
    chk("csrw_we_cycles", obs_cwe, 1);
    chk("csrw_wdata", obs_cwd, 32'h80000000);
    chk("csrw_addr", obs_caddr, 12'h7B1);
    chk("csrw_lat", obs_lat, 2);

    illegal_en = 1'b1;
    run_cmd("aar_wr_csr_ill", 32'h002307B1, 32'h80000000, 0, mk(0, 0, 1, 0));
    illegal_en = 1'b0;

    csr_val = 32'h12345678;
    run_cmd("aar_rd_csr", 32'h00220300, 0, 0, mk(1, 32'h12345678, 0, 0));
    chk("csrr_re_cycles", obs_cre, 1);

    run_cmd("aar_wr_x7", 32'h00231007, 32'hCAFEF00D, 0, mk(0, 0, 0, 0));
    chk("x7w_rf_we_cycles", obs_rfwe, 1);
    run_cmd("aar_rd_x7", 32'h00221007, 0, 0, mk(1, 32'hCAFEF00D, 0, 0));
    chk("x7r_rf_addr", obs_rfa, 7);

    rdata_val = 32'hAB000000;
    run_cmd("aam_rd_b", 32'h02000000, 0, 32'h00000103, mk(1, 32'h000000AB, 0, 0));
    chk("aamb_size", obs_msz, 0);
    chk("aamb_addr", obs_maddr, 32'h00000103);
    chk("aamb_req_cycles", obs_mreq, 1);

    rdata_val = 32'h55667788;
    run_cmd("aam_rd_h", 32'h02100000, 0, 32'h00000102, mk(1, 32'h00005566, 0, 0));
    chk("aamh_size", obs_msz, 1);

    run_cmd("aam_rd_w_mis", 32'h02200000, 0, 32'h00000102, mk(0, 0, 0, 1));
    chk("mis_req_cycles", obs_mreq, 0);

    run_cmd("aam_wr_b", 32'h02010000, 32'h11223344, 32'h00000201, mk(0, 0, 0, 0));
    chk("aamwb_wdata", obs_mwd, 32'h44444444);
    chk("aamwb_size", obs_msz, 0);

    gnt_en = 1'b0;
    run_cmd("aam_wr_tmo", 32'h02210000, 32'h1, 32'h00000200, mk(0, 0, 0, 1));
    chk("tmo_req_cycles", obs_mreq, 64);
    gnt_en = 1'b1;

    err_val = 1'b1;
    run_cmd("aam_rd_err", 32'h02200000, 0, 32'h00000300, mk(0, 0, 0, 1));
    err_val = 1'b0;

    run_cmd("aar_postexec", 32'h00261005, 0, 0, mk(0, 0, 1, 0));
    chk("pe_strobes", obs_cwe + obs_cre + obs_rfwe, 0);

    run_cmd("unsup_type", 32'h01000000, 0, 0, mk(0, 0, 0, 0));
    run_cmd("aar_size3", 32'h00321005, 0, 0, mk(0, 0, 0, 0));
    chk("sz3_strobes", obs_cwe + obs_cre + obs_rfwe, 0);
    run_cmd("aar_bad_regno", 32'h00222000, 0, 0, mk(0, 0, 1, 0));
    run_cmd("aar_no_xfer", 32'h00201005, 0, 0, mk(0, 0, 0, 0));
    chk("noxfer_lat", obs_lat, 2);

    // Reset in the middle of a memory response wait.
    resp_en = 1'b0;
    @(negedge clk);
    dm_if.command = 32'h02200000; dm_if.data1_in = 32'h00000400; dm_if.exec = 1'b1;
    seen = 0;
    for (int c = 0; c < 20 && seen == 0; c++) begin
      @(negedge clk);
      if (mem_if.mem_req && mem_if.mem_gnt) seen = 1;
    end
    chk("rst_test_gnt_seen", seen, 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mrst_done", dm_if.done, 0);
    chk("mrst_data0", dm_if.data0_out, 0);
    chk("mrst_write", dm_if.write, 0);
    chk("mrst_mem_req", mem_if.mem_req, 0);
    chk("mrst_mem_addr", mem_if.mem_addr, 0);
    chk("mrst_exc_bus", {dm_if.exception, dm_if.bus}, 0);
    dm_if.exec = 1'b0;
    resp_en = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    n_done = 0;
    repeat (6) begin
      @(negedge clk);
      if (dm_if.done) n_done++;
    end
    chk("mrst_no_done", n_done, 0);
    chk("sb_drained", sb_q.size(), 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/debug_cmd_seq.md
Name: debug_cmd_seq

Overview:
- Hart-side abstract command executor paired with the debug module.
- Accepts the DM's exec/command handshake and sequences Access Register (GPR/CSR) and Access Memory commands against the hart register file, CSR file and a data-memory master port.
- Returns done, exception, bus and read data (data0_out/write) to the DM, which owns cmderr, busy, postincrement and autoexec.

Parameters:
- TimeoutCycles, 64, memory grant/response watchdog in cycles; 0 disables the watchdog.
- GprBase, 16'h1000, regno of x0; GPRs occupy GprBase..GprBase+31.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- exec  in  1  DM level request; held until done
- command  in  32  abstract command word
- data0_in  in  32  DM data0 (write data)
- data1_in  in  32  DM data1 (memory address)
- data0_out  out  32  read result to data0
- write  out  1  data0_out valid, 1-cycle pulse
- done  out  1  command finished, 1-cycle pulse
- exception  out  1  qualifies done
- bus  out  1  qualifies done
- rf_addr  out  5  GPR index
- rf_we  out  1  GPR write strobe
- rf_wdata  out  32  GPR write data
- rf_rdata  in  32  GPR read data, 1-cycle synchronous
- csr_addr  out  12  CSR address
- csr_re  out  1  CSR read strobe
- csr_we  out  1  CSR write strobe
- csr_wdata  out  32  CSR write data
- csr_rdata  in  32  CSR read data, combinational
- csr_illegal  in  1  CSR address invalid, combinational with re/we
- mem_req  out  1  memory request, held until mem_gnt
- mem_we  out  1  memory write
- mem_addr  out  32  byte address
- mem_size  out  2  0=byte, 1=half, 2=word
- mem_wdata  out  32  write data, lane-replicated
- mem_gnt  in  1  request accepted
- mem_rvalid  in  1  response valid
- mem_rdata  in  32  response data
- mem_err  in  1  response error, qualified by rvalid

Behaviour:
- Reset: all outputs 0; state IDLE; watchdog counter 0. A reset mid-command aborts it with no done.
- Command decode:
  - cmdtype = [31:24]: 0 = AAR, 2 = AAM, other = unsupported.
  - size = [22:20].
  - AAR fields: postexec [18], transfer [17], write [16], regno [15:0].
- States: IDLE, DECODE, RF_READ, MEM_REQ, MEM_WAIT, FINISH.
- IDLE: exec=1 moves to DECODE. command is captured at this edge and held until FINISH.
- DECODE:
  - AAR with postexec=1: exception.
  - AAR with transfer=0: done only.
  - AAR with size!=2, AAM with size>2, or unsupported cmdtype: done with no access and no flags. The DM reports not-supported.
  - AAR with regno < 16'h1000: CSR access in this cycle via csr_re or csr_we. csr_illegal=1 gives exception; otherwise a read updates data0_out and pulses write. Then FINISH.
  - AAR with regno in GprBase..+31: a write asserts rf_we for one cycle, then FINISH. A read goes to RF_READ. x0 writes are issued and discarded by the regfile.
  - AAR with any other regno: exception.
  - AAM with data1_in misaligned for size: bus=1, no request.
  - AAM otherwise: MEM_REQ.
- RF_READ: data0_out = rf_rdata, write=1, then FINISH. Total latency is 3 cycles from exec to done.
- MEM_REQ: mem_req=1 with stable addr, size, we and wdata until mem_gnt, then MEM_WAIT.
- MEM_WAIT: on mem_rvalid, move to FINISH.
  - mem_err=1 sets bus.
  - Otherwise a read extracts the lane by addr[1:0], zero-extends to 32 bits and pulses write.
- Watchdog: counts in MEM_REQ and MEM_WAIT and clears on entering MEM_REQ. Reaching TimeoutCycles drops mem_req, sets bus and goes to FINISH. A late rvalid in IDLE is ignored.
- FINISH: done=1 for one cycle together with any exception/bus flag, then IDLE. The DM clears exec on the done edge, so no re-trigger occurs.
- Priority within a cycle: exception over bus; at most one flag per command.
- exec dropping before done (DM reset) aborts the command: return to IDLE immediately. A granted memory access is not retracted.

Decomposition:
- Shared debug package holds:
  - cmdtype encodings and field-extract macros (size, postexec, transfer, write, regno, aampostincrement).
  - The state enum and GprBase.
  - These match the DM's command macros so both sides decode identically.
- One sub-module, debug_cmd_lane: combinational byte/half lane extract with zero-extend and write-data replication. It is shared with the memory path.

Test Plan:
- AAR read x5 (regno 0x1005), rf x5=0xDEADBEEF: rf_addr=5; write and done both at cycle 3 with data0_out=0xDEADBEEF; no flags.
- AAR write CSR 0x7B1 with data0_in=0x80000000: csr_we one cycle with csr_wdata=0x80000000, done next cycle. Repeat with csr_illegal=1: done with exception=1.
- AAM byte read, data1_in=0x00000103, mem_rdata=0xAB000000: mem_size=0, data0_out=0x000000AB, done with no flags.
- AAM word read at 0x00000102: no mem_req issued; done with bus=1.
- AAM write with mem_gnt held 0 and TimeoutCycles=64: mem_req drops after 64 cycles; done with bus=1.
- AAR with postexec=1: done with exception=1 and no rf/csr strobe. Then assert rst_n low mid-MEM_WAIT: all outputs 0 and no done.
